// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared defaults and dump FSM encoding for the bypassing
//               register file and its dump streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int c_DEF_BANK_SIZE   = 32;
    localparam int c_DEF_DATA_LENGTH = 32;
    localparam int c_DEF_ADDR_LENGTH = 5;
    localparam int c_DEF_NUM_RD      = 2;
    localparam int c_DEF_ZERO_REG    = 1;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/register_file_bypass_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_bypass_if
// Description : Write, read and dump-stream signals of the register file.
//               The slave side is the register file; the master side is the
//               pipeline / debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_bypass_if
    import register_file_pkg::*;
#(
    parameter int BANK_SIZE   = c_DEF_BANK_SIZE,
    parameter int DATA_LENGTH = c_DEF_DATA_LENGTH,
    parameter int ADDR_LENGTH = c_DEF_ADDR_LENGTH,
    parameter int NUM_RD      = c_DEF_NUM_RD
);
    logic                          i_wr_en;
    logic [ADDR_LENGTH-1:0]        i_wr_addr;
    logic [DATA_LENGTH-1:0]        i_wr_data;
    logic [NUM_RD*ADDR_LENGTH-1:0] i_rd_addr;
    logic [NUM_RD*DATA_LENGTH-1:0] o_rd_data;
    logic                          i_dump_start;
    logic                          o_dump_valid;
    logic                          i_dump_ready;
    logic [ADDR_LENGTH-1:0]        o_dump_addr;
    logic [DATA_LENGTH-1:0]        o_dump_data;
    logic                          o_dump_last;
    logic                          o_dump_busy;
    logic                          o_dump_done;

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_dump_start, i_dump_ready,
        output o_rd_data, o_dump_valid, o_dump_addr, o_dump_data, o_dump_last,
               o_dump_busy, o_dump_done
    );

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_dump_start, i_dump_ready,
        input  o_rd_data, o_dump_valid, o_dump_addr, o_dump_data, o_dump_last,
               o_dump_busy, o_dump_done
    );

endinterface
`default_nettype wire

// File: rtl/reg_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_streamer
// Description : Walks the register bank from index 0 to BANK_SIZE-1 and
//               presents each word as a valid/ready beat. Words are captured
//               through a read tap supplied by the bank owner.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_streamer
    import register_file_pkg::*;
#(
    parameter int BANK_SIZE   = c_DEF_BANK_SIZE,
    parameter int DATA_LENGTH = c_DEF_DATA_LENGTH,
    parameter int ADDR_LENGTH = c_DEF_ADDR_LENGTH
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic                   i_start,
    input  wire logic                   i_ready,
    input  wire logic [DATA_LENGTH-1:0] i_tap_data,
    output logic      [ADDR_LENGTH-1:0] o_tap_addr,
    output logic                        o_valid,
    output logic      [ADDR_LENGTH-1:0] o_addr,
    output logic      [DATA_LENGTH-1:0] o_data,
    output logic                        o_last,
    output logic                        o_busy,
    output logic                        o_done
);
    localparam logic [ADDR_LENGTH-1:0] c_LAST_IDX = ADDR_LENGTH'(BANK_SIZE - 1);

    dump_state_e            state_q, state_d;
    logic [ADDR_LENGTH-1:0] ptr_q,   ptr_d;
    logic [DATA_LENGTH-1:0] cap_q,   cap_d;

    // State, pointer and captured word registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= DUMP_IDLE;
            ptr_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cap_q   <= cap_d;
        end
    end

    // Next-state and beat outputs; the tap always points at the word to be
    // captured next, so the capture sees same-cycle writes via the bypass
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cap_d      = cap_q;
        o_tap_addr = '0;
        o_valid    = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_last     = 1'b0;
        o_addr     = ptr_q;
        o_data     = cap_q;
        case (state_q)
            DUMP_IDLE: begin
                if (i_start) begin
                    ptr_d   = '0;
                    cap_d   = i_tap_data;
                    state_d = DUMP_SEND;
                end
            end
            DUMP_SEND: begin
                o_valid    = 1'b1;
                o_busy     = 1'b1;
                o_last     = (ptr_q == c_LAST_IDX);
                o_tap_addr = ptr_q + 1'b1;
                if (i_ready) begin
                    if (ptr_q == c_LAST_IDX) begin
                        state_d = DUMP_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                        cap_d = i_tap_data;
                    end
                end
            end
            DUMP_DONE: begin
                o_done  = 1'b1;
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/register_file_bypass.sv
`default_nettype none
// ============================================================================
// Module      : register_file_bypass
// Description : Register bank with NUM_RD combinational read ports,
//               write-to-read bypass, optional hardwired-zero register 0 and
//               a handshaked dump stream for the debug unit.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_bypass
    import register_file_pkg::*;
#(
    parameter int BANK_SIZE   = c_DEF_BANK_SIZE,
    parameter int DATA_LENGTH = c_DEF_DATA_LENGTH,
    parameter int ADDR_LENGTH = c_DEF_ADDR_LENGTH,
    parameter int NUM_RD      = c_DEF_NUM_RD,
    parameter int ZERO_REG    = c_DEF_ZERO_REG
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    register_file_bypass_if.slave  bus
);
    logic [DATA_LENGTH-1:0]        bank_q [BANK_SIZE];
    logic [NUM_RD*DATA_LENGTH-1:0] w_rd_data;
    logic [ADDR_LENGTH-1:0]        w_tap_addr;
    logic [DATA_LENGTH-1:0]        w_tap_data;
    logic                          w_wr_ok;

    // Read rule shared by every read port and the dump tap
    function automatic logic [DATA_LENGTH-1:0] read_path(
        input logic [ADDR_LENGTH-1:0] idx,
        input logic [DATA_LENGTH-1:0] stored,
        input logic                   wr_en,
        input logic [ADDR_LENGTH-1:0] wr_addr,
        input logic [DATA_LENGTH-1:0] wr_data
    );
        if ((ZERO_REG != 0) && (idx == '0)) begin
            return '0;
        end else if (wr_en && (wr_addr == idx)) begin
            return wr_data;
        end
        return stored;
    endfunction

    assign w_wr_ok = bus.i_wr_en && !((ZERO_REG != 0) && (bus.i_wr_addr == '0));

    // Bank storage: cleared by reset, written from WB
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BANK_SIZE; i++) begin
                bank_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            bank_q[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // Read ports with same-cycle bypass
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_data[k*DATA_LENGTH +: DATA_LENGTH] =
                read_path(bus.i_rd_addr[k*ADDR_LENGTH +: ADDR_LENGTH],
                          bank_q[bus.i_rd_addr[k*ADDR_LENGTH +: ADDR_LENGTH]],
                          bus.i_wr_en, bus.i_wr_addr, bus.i_wr_data);
        end
    end

    assign bus.o_rd_data = w_rd_data;

    assign w_tap_data = read_path(w_tap_addr, bank_q[w_tap_addr],
                                  bus.i_wr_en, bus.i_wr_addr, bus.i_wr_data);

    reg_dump_streamer #(
        .BANK_SIZE   (BANK_SIZE),
        .DATA_LENGTH (DATA_LENGTH),
        .ADDR_LENGTH (ADDR_LENGTH)
    ) u_dump (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (bus.i_dump_start),
        .i_ready    (bus.i_dump_ready),
        .i_tap_data (w_tap_data),
        .o_tap_addr (w_tap_addr),
        .o_valid    (bus.o_dump_valid),
        .o_addr     (bus.o_dump_addr),
        .o_data     (bus.o_dump_data),
        .o_last     (bus.o_dump_last),
        .o_busy     (bus.o_dump_busy),
        .o_done     (bus.o_dump_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file_bypass.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_bypass
// Description : Self-checking bench for register_file_bypass. Two instances:
//               dut_a with hardwired zero register, dut_b without.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_bypass;
    import register_file_pkg::*;

    localparam int BS = 32;
    localparam int DL = 32;
    localparam int AL = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_file_bypass_if #(.BANK_SIZE(BS), .DATA_LENGTH(DL), .ADDR_LENGTH(AL), .NUM_RD(NR)) bus_a ();
    register_file_bypass_if #(.BANK_SIZE(BS), .DATA_LENGTH(DL), .ADDR_LENGTH(AL), .NUM_RD(NR)) bus_b ();

    register_file_bypass #(.BANK_SIZE(BS), .DATA_LENGTH(DL), .ADDR_LENGTH(AL), .NUM_RD(NR), .ZERO_REG(1))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
    register_file_bypass #(.BANK_SIZE(BS), .DATA_LENGTH(DL), .ADDR_LENGTH(AL), .NUM_RD(NR), .ZERO_REG(0))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

    // Architectural register contents as seen after the most recent edge
    logic [31:0] model_a [32];
    logic [31:0] model_b [32];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] ref_read(input bit zr, input logic [31:0] m [32], input int idx,
                                             input bit we, input int wa, input logic [31:0] wd);
        if (zr && idx == 0) return 32'h0;
        if (we && wa == idx) return wd;
        return m[idx];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
    endtask

    task automatic drive_idle();
        bus_a.i_wr_en = 0; bus_a.i_wr_addr = '0; bus_a.i_wr_data = '0; bus_a.i_rd_addr = '0;
        bus_a.i_dump_start = 0; bus_a.i_dump_ready = 0;
        bus_b.i_wr_en = 0; bus_b.i_wr_addr = '0; bus_b.i_wr_data = '0; bus_b.i_rd_addr = '0;
        bus_b.i_dump_start = 0; bus_b.i_dump_ready = 0;
    endtask

    task automatic write_both(input bit we, input int wa, input logic [31:0] wd, input int r0, input int r1);
        bus_a.i_wr_en = we; bus_a.i_wr_addr = AL'(wa); bus_a.i_wr_data = wd;
        bus_b.i_wr_en = we; bus_b.i_wr_addr = AL'(wa); bus_b.i_wr_data = wd;
        bus_a.i_rd_addr = {AL'(r1), AL'(r0)};
        bus_b.i_rd_addr = {AL'(r1), AL'(r0)};
        if (we && wa != 0) model_a[wa] = wd;
        if (we) model_b[wa] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus_a.i_wr_en = 1; bus_a.i_wr_addr = 5'd3; bus_a.i_wr_data = 32'hFFFF_FFFF; bus_a.i_dump_start = 1;
        bus_b.i_wr_en = 1; bus_b.i_wr_addr = 5'd3; bus_b.i_wr_data = 32'hFFFF_FFFF; bus_b.i_dump_start = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus_a.o_dump_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus_a.o_dump_valid); end
        n_cmp++; if (bus_a.o_dump_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus_a.o_dump_busy); end
        n_cmp++; if (bus_a.o_dump_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus_a.o_dump_done); end
        n_cmp++; if (bus_a.o_dump_last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%b exp=0", bus_a.o_dump_last); end
        n_cmp++; if (bus_a.o_dump_addr !== '0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", bus_a.o_dump_addr); end
        n_cmp++; if (bus_a.o_dump_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bus_a.o_dump_data); end
        rst = 1'b0;
        drive_idle();
        clear_models();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            write_both(0, 0, 0, i, i);
            #1;
            n_cmp++; if (bus_a.o_rd_data !== 64'h0) begin n_err++; $display("FAIL reset_read_a idx=%0d got=%h exp=0", i, bus_a.o_rd_data); end
            n_cmp++; if (bus_b.o_rd_data !== 64'h0) begin n_err++; $display("FAIL reset_read_b idx=%0d got=%h exp=0", i, bus_b.o_rd_data); end
        end
        n_cmp++; if (bus_a.o_dump_busy !== 1'b0) begin n_err++; $display("FAIL reset_start_ignored busy=%b exp=0", bus_a.o_dump_busy); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        write_both(1, 5, 32'hDEAD_BEEF, 0, 0);
        @(negedge clk);
        write_both(0, 0, 0, 5, 5);
        #1;
        n_cmp++; if (bus_a.o_rd_data[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_read got=%h exp=deadbeef", bus_a.o_rd_data[31:0]); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        write_both(1, 7, 32'h1234_5678, 7, 7);
        #1;
        n_cmp++; if (bus_a.o_rd_data !== {2{32'h1234_5678}}) begin n_err++; $display("FAIL bypass_both got=%h exp=%h", bus_a.o_rd_data, {2{32'h1234_5678}}); end
        @(negedge clk);
        write_both(0, 0, 0, 7, 7);
        #1;
        n_cmp++; if (bus_a.o_rd_data !== {2{32'h1234_5678}}) begin n_err++; $display("FAIL bypass_stored got=%h exp=%h", bus_a.o_rd_data, {2{32'h1234_5678}}); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        write_both(1, 0, 32'hFFFF_FFFF, 0, 0);
        #1;
        n_cmp++; if (bus_a.o_rd_data !== 64'h0) begin n_err++; $display("FAIL zero_bypass_a got=%h exp=0", bus_a.o_rd_data); end
        n_cmp++; if (bus_b.o_rd_data !== {2{32'hFFFF_FFFF}}) begin n_err++; $display("FAIL zero_bypass_b got=%h exp=all ones", bus_b.o_rd_data); end
        @(negedge clk);
        write_both(0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (bus_a.o_rd_data !== 64'h0) begin n_err++; $display("FAIL zero_stored_a got=%h exp=0", bus_a.o_rd_data); end
        n_cmp++; if (bus_b.o_rd_data !== {2{32'hFFFF_FFFF}}) begin n_err++; $display("FAIL zero_stored_b got=%h exp=all ones", bus_b.o_rd_data); end
    endtask

    task automatic test_random_rw();
        bit we; int wa, r0, r1; logic [31:0] wd;
        logic [31:0] ea0, ea1, eb0, eb1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            we = 1'($urandom_range(1)); wa = $urandom_range(31); wd = $urandom;
            r0 = ($urandom_range(3) == 0) ? wa : $urandom_range(31);
            r1 = ($urandom_range(3) == 0) ? r0 : $urandom_range(31);
            ea0 = ref_read(1, model_a, r0, we, wa, wd); ea1 = ref_read(1, model_a, r1, we, wa, wd);
            eb0 = ref_read(0, model_b, r0, we, wa, wd); eb1 = ref_read(0, model_b, r1, we, wa, wd);
            write_both(we, wa, wd, r0, r1);
            #1;
            n_cmp++; if (bus_a.o_rd_data !== {ea1, ea0}) begin n_err++; $display("FAIL rand_rw_a c=%0d got=%h exp=%h", c, bus_a.o_rd_data, {ea1, ea0}); end
            n_cmp++; if (bus_b.o_rd_data !== {eb1, eb0}) begin n_err++; $display("FAIL rand_rw_b c=%0d got=%h exp=%h", c, bus_b.o_rd_data, {eb1, eb0}); end
        end
        @(negedge clk);
        write_both(0, 0, 0, 0, 0);
    endtask

    // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready
    // wmode: 0 no writes, 1 single write 10<=0xAA while beat 3 pending, 2 random writes
    task automatic run_dump(input int rmode, input int wmode, input int abort_at);
        int idx, phase, cyc, wa; bit fin, wrote10, rdy; logic [31:0] exp, wd;
        @(negedge clk);
        drive_idle();
        bus_a.i_dump_start = 1;
        idx = 0; exp = model_a[0]; phase = 1; cyc = 0; fin = 0; wrote10 = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus_a.i_dump_start = 0;
            bus_a.i_wr_en = 0;
            if (phase == 1) begin
                n_cmp++; if (bus_a.o_dump_valid !== 1'b1) begin n_err++; $display("FAIL dump_valid idx=%0d got=%b exp=1", idx, bus_a.o_dump_valid); end
                n_cmp++; if (bus_a.o_dump_busy !== 1'b1) begin n_err++; $display("FAIL dump_busy idx=%0d got=%b exp=1", idx, bus_a.o_dump_busy); end
                n_cmp++; if (bus_a.o_dump_addr !== AL'(idx)) begin n_err++; $display("FAIL dump_addr got=%0d exp=%0d", bus_a.o_dump_addr, idx); end
                n_cmp++; if (bus_a.o_dump_data !== exp) begin n_err++; $display("FAIL dump_data idx=%0d got=%h exp=%h", idx, bus_a.o_dump_data, exp); end
                n_cmp++; if (bus_a.o_dump_last !== (idx == 31)) begin n_err++; $display("FAIL dump_last idx=%0d got=%b", idx, bus_a.o_dump_last); end
                n_cmp++; if (bus_a.o_dump_done !== 1'b0) begin n_err++; $display("FAIL dump_done_early idx=%0d got=%b exp=0", idx, bus_a.o_dump_done); end
                if (idx == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    clear_models();
                    n_cmp++; if (bus_a.o_dump_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid got=%b exp=0", bus_a.o_dump_valid); end
                    n_cmp++; if (bus_a.o_dump_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus_a.o_dump_busy); end
                    n_cmp++; if (bus_a.o_dump_done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b exp=0", bus_a.o_dump_done); end
                    @(negedge clk);
                    n_cmp++; if (bus_a.o_dump_done !== 1'b0) begin n_err++; $display("FAIL abort_done_late got=%b exp=0", bus_a.o_dump_done); end
                    fin = 1;
                end else begin
                    case (rmode)
                        0: rdy = 1;
                        1: rdy = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
                        default: rdy = 1'($urandom_range(1));
                    endcase
                    bus_a.i_dump_ready = rdy;
                    if (rmode == 0 && idx == 5) bus_a.i_dump_start = 1;
                    if ((wmode == 1 && idx == 3 && !wrote10) || (wmode == 2 && $urandom_range(1) == 1)) begin
                        wa = (wmode == 1) ? 10 : $urandom_range(31);
                        wd = (wmode == 1) ? 32'hAA : $urandom;
                        wrote10 = 1;
                        bus_a.i_wr_en = 1; bus_a.i_wr_addr = AL'(wa); bus_a.i_wr_data = wd;
                        if (wa != 0) model_a[wa] = wd;
                    end
                    if (rdy) begin
                        if (idx == 31) phase = 2;
                        else begin idx++; exp = model_a[idx]; end
                    end
                end
            end else if (phase == 2) begin
                n_cmp++; if (bus_a.o_dump_done !== 1'b1) begin n_err++; $display("FAIL done_pulse got=%b exp=1", bus_a.o_dump_done); end
                n_cmp++; if (bus_a.o_dump_valid !== 1'b0) begin n_err++; $display("FAIL done_valid got=%b exp=0", bus_a.o_dump_valid); end
                if (rmode == 0) begin
                    n_cmp++; if (cyc !== 33) begin n_err++; $display("FAIL done_latency got=%0d exp=33", cyc); end
                end
                bus_a.i_dump_start = 1;
                bus_a.i_dump_ready = 0;
                phase = 3;
            end else begin
                n_cmp++; if (bus_a.o_dump_done !== 1'b0) begin n_err++; $display("FAIL done_width got=%b exp=0", bus_a.o_dump_done); end
                n_cmp++; if (bus_a.o_dump_busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", bus_a.o_dump_busy); end
                n_cmp++; if (bus_a.o_dump_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got=%b exp=0", bus_a.o_dump_valid); end
                fin = 1;
            end
        end
        n_cmp++; if (!fin) begin n_err++; $display("FAIL dump_timeout got=%0d cycles exp=finished", cyc); end
        drive_idle();
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            write_both(1, i, 32'(i * 3), 0, 0);
        end
        run_dump(0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_dump(1, 1, -1);
        run_dump(2, 2, -1);
    endtask

    task automatic test_reset_mid_dump();
        run_dump(0, 0, 12);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            write_both(0, 0, 0, i, 31 - i);
            #1;
            n_cmp++; if (bus_a.o_rd_data !== 64'h0) begin n_err++; $display("FAIL abort_regs idx=%0d got=%h exp=0", i, bus_a.o_rd_data); end
        end
        run_dump(0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_random_rw();
        test_full_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
